ibex_wb_buffer: RTL and testbench



---
 rtl/ibex_pkg.sv | 13 +
 rtl/ibex_wb_buffer.sv | 155 +++++++++++++++
 tb/tb_ibex_wb_buffer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// ibex_pkg: shared type definitions for the core. Only the items used by the
// writeback buffer are defined here.
//   rv32f_e : floating-point extension selection
//     RV32FNone   - no FP register file; FP writes never occur
//     RV32Fbfloat - bfloat16 FP register file present
package ibex_pkg;

  typedef enum integer {
    RV32FNone   = 0,
    RV32Fbfloat = 1
  } rv32f_e;

endpackage

// File: rtl/ibex_wb_buffer.sv
// ibex_wb_buffer: single-entry writeback stage behind the execute block.
// Captures one EX result (integer or FP), optionally waits for the LSU
// response of a load/store, then issues exactly one register-file write.
// The held ALU/FP result is exposed for operand forwarding.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   en_wb_i                 ID hands an instruction to WB this cycle
//   instr_type_i[1:0]       0 ALU/FP, 1 load, 2 store, 3 reserved (ALU, no write)
//   rf_we_i, rf_waddr_i     destination write request and index
//   fp_sel_i                destination is the FP register file
//   ex_valid_i, result_ex_i EX result and its valid
//   lsu_resp_valid_i        LSU response for the held load/store
//   lsu_resp_err_i          LSU response is a bus error
//   lsu_rdata_i             load data
//   ready_wb_o              WB can accept an instruction this cycle
//   rf_we_wb_o, fp_we_wb_o  integer / FP register file write enables
//   rf_waddr_wb_o           write address shared by both files
//   rf_wdata_wb_o           write data
//   fwd_valid_o, fwd_fp_o   forwarding valid and target file
//   fwd_data_o              held ALU/FP result
//   instr_done_o            held instruction retires this cycle
//   outstanding_load_o      load held, response pending
//   outstanding_store_o     store held, response pending
//   lsu_err_o               held load/store retired with an error
module ibex_wb_buffer #(
  parameter ibex_pkg::rv32f_e RV32F = ibex_pkg::RV32Fbfloat
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        en_wb_i,
  input  logic [1:0]  instr_type_i,
  input  logic        rf_we_i,
  input  logic [4:0]  rf_waddr_i,
  input  logic        fp_sel_i,

  input  logic        ex_valid_i,
  input  logic [31:0] result_ex_i,

  input  logic        lsu_resp_valid_i,
  input  logic        lsu_resp_err_i,
  input  logic [31:0] lsu_rdata_i,

  output logic        ready_wb_o,

  output logic        rf_we_wb_o,
  output logic        fp_we_wb_o,
  output logic [4:0]  rf_waddr_wb_o,
  output logic [31:0] rf_wdata_wb_o,

  output logic        fwd_valid_o,
  output logic        fwd_fp_o,
  output logic [31:0] fwd_data_o,

  output logic        instr_done_o,
  output logic        outstanding_load_o,
  output logic        outstanding_store_o,
  output logic        lsu_err_o
);

  localparam logic [1:0] TYPE_ALU   = 2'd0;
  localparam logic [1:0] TYPE_LOAD  = 2'd1;
  localparam logic [1:0] TYPE_STORE = 2'd2;
  localparam logic [1:0] TYPE_RSVD  = 2'd3;

  localparam bit HAS_FP = (RV32F != ibex_pkg::RV32FNone);

  logic        valid_q;
  logic [1:0]  type_q;
  logic        we_q;
  logic        fp_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        done;
  logic        is_load_q;
  logic        is_store_q;
  logic        is_lsu_q;
  logic        load_err;
  logic        fp_sel_eff;
  logic [1:0]  type_d;
  logic        we_d;

  // Decode of the incoming instruction. Reserved encodings are held as ALU
  // ops that never write, so they retire one cycle after capture.
  assign fp_sel_eff = HAS_FP & fp_sel_i;

  always_comb begin
    type_d = instr_type_i;
    we_d   = rf_we_i;
    if (instr_type_i == TYPE_RSVD) begin
      type_d = TYPE_ALU;
      we_d   = 1'b0;
    end else if (instr_type_i == TYPE_STORE) begin
      we_d   = 1'b0;
    end
  end

  // Retirement: ALU results retire as soon as they are held; memory ops wait
  // for the LSU response. A response while nothing memory-related is held
  // cannot retire anything because it is qualified by is_lsu_q.
  assign is_load_q  = (type_q == TYPE_LOAD);
  assign is_store_q = (type_q == TYPE_STORE);
  assign is_lsu_q   = is_load_q | is_store_q;

  assign done     = valid_q & (is_lsu_q ? lsu_resp_valid_i : 1'b1);
  assign load_err = is_load_q & lsu_resp_err_i;

  assign ready_wb_o = ~valid_q | done;
  assign accept     = en_wb_i & ex_valid_i & ready_wb_o;

  // Capture stage boundary: holds one instruction until it retires.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      type_q  <= TYPE_ALU;
      we_q    <= 1'b0;
      fp_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      valid_q <= 1'b1;
      type_q  <= type_d;
      we_q    <= we_d;
      fp_q    <= fp_sel_eff;
      waddr_q <= rf_waddr_i;
      wdata_q <= result_ex_i;
    end else if (done) begin
      valid_q <= 1'b0;
    end
  end

  // Register-file write port. x0 is hardwired so integer writes to it are
  // dropped; f0 is a real register and is written. A faulting load retires
  // without writing.
  assign rf_waddr_wb_o = waddr_q;
  assign rf_wdata_wb_o = is_load_q ? lsu_rdata_i : wdata_q;

  assign rf_we_wb_o = done & we_q & ~fp_q & (waddr_q != 5'd0) & ~load_err;
  assign fp_we_wb_o = HAS_FP & done & we_q & fp_q & ~load_err;

  // Forwarding only ever exposes the registered ALU/FP result; load data
  // arrives combinationally from the LSU and is not forwarded.
  assign fwd_valid_o = valid_q & (type_q == TYPE_ALU) & we_q;
  assign fwd_fp_o    = fp_q;
  assign fwd_data_o  = wdata_q;

  assign instr_done_o        = done;
  assign outstanding_load_o  = valid_q & is_load_q;
  assign outstanding_store_o = valid_q & is_store_q;
  assign lsu_err_o           = done & is_lsu_q & lsu_resp_err_i;

endmodule

// File: tb/tb_ibex_wb_buffer.sv
// Testbench for ibex_wb_buffer: table of per-cycle vectors plus hand-written
// sequences for the FP-less configuration and reset during a store.
module tb_ibex_wb_buffer;

  logic        clk_i;
  logic        rst_ni;
  logic        en_wb_i;
  logic [1:0]  instr_type_i;
  logic        rf_we_i;
  logic [4:0]  rf_waddr_i;
  logic        fp_sel_i;
  logic        ex_valid_i;
  logic [31:0] result_ex_i;
  logic        lsu_resp_valid_i;
  logic        lsu_resp_err_i;
  logic [31:0] lsu_rdata_i;

  logic        ready_wb_o, rf_we_wb_o, fp_we_wb_o;
  logic [4:0]  rf_waddr_wb_o;
  logic [31:0] rf_wdata_wb_o;
  logic        fwd_valid_o, fwd_fp_o;
  logic [31:0] fwd_data_o;
  logic        instr_done_o, outstanding_load_o, outstanding_store_o, lsu_err_o;

  logic        n_ready, n_rf_we, n_fp_we;
  logic [4:0]  n_waddr;
  logic [31:0] n_wdata;
  logic        n_fwd_valid, n_fwd_fp;
  logic [31:0] n_fwd_data;
  logic        n_done, n_oload, n_ostore, n_err;

  ibex_wb_buffer #(.RV32F(ibex_pkg::RV32Fbfloat)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .en_wb_i(en_wb_i), .instr_type_i(instr_type_i), .rf_we_i(rf_we_i),
    .rf_waddr_i(rf_waddr_i), .fp_sel_i(fp_sel_i),
    .ex_valid_i(ex_valid_i), .result_ex_i(result_ex_i),
    .lsu_resp_valid_i(lsu_resp_valid_i), .lsu_resp_err_i(lsu_resp_err_i),
    .lsu_rdata_i(lsu_rdata_i),
    .ready_wb_o(ready_wb_o), .rf_we_wb_o(rf_we_wb_o), .fp_we_wb_o(fp_we_wb_o),
    .rf_waddr_wb_o(rf_waddr_wb_o), .rf_wdata_wb_o(rf_wdata_wb_o),
    .fwd_valid_o(fwd_valid_o), .fwd_fp_o(fwd_fp_o), .fwd_data_o(fwd_data_o),
    .instr_done_o(instr_done_o), .outstanding_load_o(outstanding_load_o),
    .outstanding_store_o(outstanding_store_o), .lsu_err_o(lsu_err_o)
  );

  ibex_wb_buffer #(.RV32F(ibex_pkg::RV32FNone)) dut_nofp (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .en_wb_i(en_wb_i), .instr_type_i(instr_type_i), .rf_we_i(rf_we_i),
    .rf_waddr_i(rf_waddr_i), .fp_sel_i(fp_sel_i),
    .ex_valid_i(ex_valid_i), .result_ex_i(result_ex_i),
    .lsu_resp_valid_i(lsu_resp_valid_i), .lsu_resp_err_i(lsu_resp_err_i),
    .lsu_rdata_i(lsu_rdata_i),
    .ready_wb_o(n_ready), .rf_we_wb_o(n_rf_we), .fp_we_wb_o(n_fp_we),
    .rf_waddr_wb_o(n_waddr), .rf_wdata_wb_o(n_wdata),
    .fwd_valid_o(n_fwd_valid), .fwd_fp_o(n_fwd_fp), .fwd_data_o(n_fwd_data),
    .instr_done_o(n_done), .outstanding_load_o(n_oload),
    .outstanding_store_o(n_ostore), .lsu_err_o(n_err)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic        en;
    logic [1:0]  typ;
    logic        we;
    logic [4:0]  wa;
    logic        fp;
    logic        exv;
    logic [31:0] res;
    logic        rv;
    logic        rerr;
    logic [31:0] rdata;
    logic [77:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // {ready, rf_we, fp_we, waddr, wdata, fwd_valid, fwd_fp, fwd_data, done, oload, ostore, err}
  function automatic logic [77:0] e(input logic rdy, input logic rfwe, input logic fpwe,
                                    input logic [4:0] wa, input logic [31:0] wd,
                                    input logic fv, input logic ffp, input logic [31:0] fd,
                                    input logic dn, input logic ol, input logic os,
                                    input logic er);
    return {rdy, rfwe, fpwe, wa, wd, fv, ffp, fd, dn, ol, os, er};
  endfunction

  function automatic vec_t mk(input logic en, input logic [1:0] typ, input logic we,
                              input logic [4:0] wa, input logic fp, input logic exv,
                              input logic [31:0] res, input logic rv, input logic rerr,
                              input logic [31:0] rdata, input logic [77:0] exp);
    vec_t v;
    v.en = en; v.typ = typ; v.we = we; v.wa = wa; v.fp = fp; v.exv = exv;
    v.res = res; v.rv = rv; v.rerr = rerr; v.rdata = rdata; v.exp = exp;
    return v;
  endfunction

  function automatic logic [77:0] pack_dut();
    return {ready_wb_o, rf_we_wb_o, fp_we_wb_o, rf_waddr_wb_o, rf_wdata_wb_o,
            fwd_valid_o, fwd_fp_o, fwd_data_o, instr_done_o, outstanding_load_o,
            outstanding_store_o, lsu_err_o};
  endfunction

  task automatic chk(input string name, input logic [77:0] act, input logic [77:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    en_wb_i          = v.en;
    instr_type_i     = v.typ;
    rf_we_i          = v.we;
    rf_waddr_i       = v.wa;
    fp_sel_i         = v.fp;
    ex_valid_i       = v.exv;
    result_ex_i      = v.res;
    lsu_resp_valid_i = v.rv;
    lsu_resp_err_i   = v.rerr;
    lsu_rdata_i      = v.rdata;
  endtask

  vec_t vecs[24];
  vec_t idle;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);

    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                  e(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs[1]  = mk(1, 0, 1, 5, 0, 1, 32'h1234, 0, 0, 0,
                  e(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs[2]  = mk(1, 0, 1, 0, 1, 1, 32'h3F80_0000, 0, 0, 0,
                  e(1, 1, 0, 5, 32'h1234, 1, 0, 32'h1234, 1, 0, 0, 0));
    vecs[3]  = mk(1, 0, 1, 0, 0, 1, 32'h3F80_0000, 0, 0, 0,
                  e(1, 0, 1, 0, 32'h3F80_0000, 1, 1, 32'h3F80_0000, 1, 0, 0, 0));
    vecs[4]  = mk(1, 0, 1, 7, 0, 0, 32'h5555, 0, 0, 0,
                  e(1, 0, 0, 0, 32'h3F80_0000, 1, 0, 32'h3F80_0000, 1, 0, 0, 0));
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                  e(1, 0, 0, 0, 32'h3F80_0000, 0, 0, 32'h3F80_0000, 0, 0, 0, 0));
    vecs[6]  = mk(1, 1, 1, 10, 0, 1, 32'h1000, 0, 0, 0,
                  e(1, 0, 0, 0, 32'h3F80_0000, 0, 0, 32'h3F80_0000, 0, 0, 0, 0));
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                  e(0, 0, 0, 10, 0, 0, 0, 32'h1000, 0, 1, 0, 0));
    vecs[8]  = mk(1, 0, 1, 3, 0, 1, 32'h7777, 0, 0, 0,
                  e(0, 0, 0, 10, 0, 0, 0, 32'h1000, 0, 1, 0, 0));
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                  e(0, 0, 0, 10, 0, 0, 0, 32'h1000, 0, 1, 0, 0));
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF,
                  e(1, 1, 0, 10, 32'hDEAD_BEEF, 0, 0, 32'h1000, 1, 1, 0, 0));
    vecs[11] = mk(1, 1, 1, 12, 0, 1, 32'h2000, 0, 0, 0,
                  e(1, 0, 0, 10, 0, 0, 0, 32'h1000, 0, 0, 0, 0));
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hBAD0_BAD0,
                  e(1, 0, 0, 12, 32'hBAD0_BAD0, 0, 0, 32'h2000, 1, 1, 0, 1));
    vecs[13] = mk(1, 2, 1, 13, 0, 1, 32'h3000, 0, 0, 0,
                  e(1, 0, 0, 12, 0, 0, 0, 32'h2000, 0, 0, 0, 0));
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                  e(0, 0, 0, 13, 32'h3000, 0, 0, 32'h3000, 0, 0, 1, 0));
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1111_1111,
                  e(1, 0, 0, 13, 32'h3000, 0, 0, 32'h3000, 1, 0, 1, 0));
    vecs[16] = mk(1, 3, 1, 6, 0, 1, 32'h6666, 0, 0, 0,
                  e(1, 0, 0, 13, 32'h3000, 0, 0, 32'h3000, 0, 0, 0, 0));
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                  e(1, 0, 0, 6, 32'h6666, 0, 0, 32'h6666, 1, 0, 0, 0));
    vecs[18] = mk(1, 0, 1, 1, 0, 1, 32'h11, 0, 0, 0,
                  e(1, 0, 0, 6, 32'h6666, 0, 0, 32'h6666, 0, 0, 0, 0));
    vecs[19] = mk(1, 0, 1, 2, 0, 1, 32'h22, 0, 0, 0,
                  e(1, 1, 0, 1, 32'h11, 1, 0, 32'h11, 1, 0, 0, 0));
    vecs[20] = mk(1, 0, 1, 3, 0, 1, 32'h33, 0, 0, 0,
                  e(1, 1, 0, 2, 32'h22, 1, 0, 32'h22, 1, 0, 0, 0));
    vecs[21] = mk(1, 0, 1, 4, 0, 1, 32'h44, 0, 0, 0,
                  e(1, 1, 0, 3, 32'h33, 1, 0, 32'h33, 1, 0, 0, 0));
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                  e(1, 1, 0, 4, 32'h44, 1, 0, 32'h44, 1, 0, 0, 0));
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h99,
                  e(1, 0, 0, 4, 32'h44, 0, 0, 32'h44, 0, 0, 0, 0));

    drive(idle);
    rst_ni = 1'b0;
    #2;
    chk("reset_state", pack_dut(), e(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk_i);
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d", i), pack_dut(), vecs[i].exp);
    end

    // FP-less build: fp_sel_i is ignored, so the result goes to the integer file.
    @(negedge clk_i);
    drive(mk(1, 0, 1, 9, 1, 1, 32'hABCD, 0, 0, 0, '0));
    @(negedge clk_i);
    drive(idle);
    #1;
    chk("fp_build_fp_we", {77'd0, fp_we_wb_o}, 78'd1);
    chk("fp_build_rf_we", {77'd0, rf_we_wb_o}, 78'd0);
    chk("nofp_rf_we",     {77'd0, n_rf_we},    78'd1);
    chk("nofp_fp_we",     {77'd0, n_fp_we},    78'd0);
    chk("nofp_fwd_fp",    {77'd0, n_fwd_fp},   78'd0);

    // Asynchronous reset while a store is outstanding.
    @(negedge clk_i);
    drive(mk(1, 2, 1, 8, 0, 1, 32'h8888, 0, 0, 0, '0));
    @(negedge clk_i);
    drive(idle);
    #1;
    chk("store_outstanding", {76'd0, outstanding_store_o, ready_wb_o}, 78'd2);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("reset_mid_store", pack_dut(), e(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("reset_mid_store_nofp", {n_ready, n_ostore, n_done, n_rf_we}, 78'b1000);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h5A5A_5A5A, '0));
    #1;
    chk("late_resp_no_done",  {77'd0, instr_done_o}, 78'd0);
    chk("late_resp_no_write", {76'd0, rf_we_wb_o, fp_we_wb_o}, 78'd0);
    chk("late_resp_ready",    {76'd0, ready_wb_o, lsu_err_o}, 78'd2);
    @(negedge clk_i);
    drive(idle);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
